// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg : shared state, entry types and constants of the fetch unit. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit_if : imem, downstream and redirect channels of the fetch
// unit. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface instr_fetch_unit_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [DATA_WIDTH-1:0] imem_req_addr;
  logic                  imem_rsp_valid;
  logic [DATA_WIDTH-1:0] imem_rsp_data;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [DATA_WIDTH-1:0] instr;
  logic [DATA_WIDTH-1:0] instr_pc;
  logic                  redirect_valid;
  logic [DATA_WIDTH-1:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
           redirect_valid, redirect_pc
  );

endinterface

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo : synchronous FIFO with push/pop/clear and occupancy flags. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             w_push;
  logic             w_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A pop frees the slot the same cycle, so push on full is accepted alongside it.
  assign w_pop  = pop_i && !empty_o && !clear_i;
  assign w_push = push_i && !clear_i && (!full_o || w_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (w_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit : fetch PC, imem request issue, prefetch buffering and
// redirect flush. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 4,
  parameter int                    MAX_OUTST  = FIFO_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  instr_fetch_unit_if.master bus
);

  localparam int OW  = $clog2(MAX_OUTST + 1);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);

  fetch_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [OW-1:0]         outst_q, outst_d;
  logic [OW-1:0]         drop_q, drop_d;

  logic                  w_req_fire;
  logic                  w_rsp_fire;
  logic                  w_credit_ok;
  logic [OW-1:0]         w_live_outst;
  logic [OW-1:0]         w_outst_after;
  logic                  w_push;
  logic                  w_pop;
  fetch_entry_t          w_push_entry;
  fetch_entry_t          w_head;
  logic [FCW-1:0]        w_if_count;
  logic                  w_if_full;
  logic                  w_if_empty;
  logic [DATA_WIDTH-1:0] w_pq_head;
  logic [OW-1:0]         w_pq_count;
  logic                  w_pq_full;
  logic                  w_pq_empty;
  logic                  w_unused_status;

  assign w_req_fire    = bus.imem_req_valid && bus.imem_req_ready;
  assign w_rsp_fire    = bus.imem_rsp_valid;
  assign w_live_outst  = outst_q - drop_q;
  assign w_outst_after = outst_q + OW'(w_req_fire) - OW'(w_rsp_fire);

  // Credits count live requests plus buffered entries, so responses always find room.
  assign w_credit_ok = (32'(w_live_outst) + 32'(w_if_count)) < 32'(FIFO_DEPTH);

  assign bus.imem_req_valid = (state_q != BOOT) && w_credit_ok &&
                              (32'(outst_q) < 32'(MAX_OUTST)) && !bus.redirect_valid;
  assign bus.imem_req_addr  = fetch_pc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    outst_d    = w_outst_after;
    drop_d     = drop_q;

    if (w_req_fire) fetch_pc_d = fetch_pc_q + DATA_WIDTH'(4);

    // Everything still in flight after this cycle belongs to the old path.
    if (bus.redirect_valid) begin
      fetch_pc_d = {bus.redirect_pc[DATA_WIDTH-1:2], 2'b00};
      drop_d     = w_outst_after;
    end else if (w_rsp_fire && (drop_q != '0)) begin
      drop_d = drop_q - 1'b1;
    end

    case (state_q)
      BOOT:       state_d = RUN;
      RUN, FLUSH: state_d = (drop_d != '0) ? FLUSH : RUN;
      default:    state_d = BOOT;
    endcase
  end

  assign w_push       = w_rsp_fire && (drop_q == '0) && !bus.redirect_valid;
  assign w_pop        = bus.instr_valid && bus.instr_ready;
  assign w_push_entry = '{pc: w_pq_head, instr: bus.imem_rsp_data};

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_instr_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .wdata_i (w_push_entry),
    .pop_i   (w_pop),
    .clear_i (bus.redirect_valid),
    .rdata_o (w_head),
    .count_o (w_if_count),
    .full_o  (w_if_full),
    .empty_o (w_if_empty)
  );

  // Address of every request, dropped or not, so it pairs with each response in order.
  fetch_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (MAX_OUTST)
  ) u_pc_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_req_fire),
    .wdata_i (fetch_pc_q),
    .pop_i   (w_rsp_fire),
    .clear_i (1'b0),
    .rdata_o (w_pq_head),
    .count_o (w_pq_count),
    .full_o  (w_pq_full),
    .empty_o (w_pq_empty)
  );

  assign w_unused_status = ^{w_if_full, w_pq_count, w_pq_full, w_pq_empty};

  assign bus.instr_valid = !w_if_empty;
  assign bus.instr       = bus.instr_valid ? w_head.instr : '0;
  assign bus.instr_pc    = bus.instr_valid ? w_head.pc : '0;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_unit : randomized scoreboard bench for instr_fetch_unit. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } fl_t;

  logic clk;
  logic rst;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(
    .RESET_PC (RESET_PC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        exp_q[$];
  fl_t         inflight[$];
  logic [31:0] model_pc;
  int          cyc;
  int          last_due;
  int          lat_min;
  int          lat_max;
  int          req_pct;
  int          n_fire;
  int          first_fire;
  int          first_valid;
  int          n_chk;
  int          n_err;
  logic        chk_flush;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // imem response driver: in-order responses once their due cycle arrives
  initial begin
    fl_t f;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      bus.imem_req_ready = ($urandom_range(99) < req_pct);
      bus.imem_rsp_valid = 1'b0;
      if (rst && inflight.size() > 0 && inflight[0].due <= cyc) begin
        f = inflight.pop_front();
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem_word(f.addr);
      end
    end
  end

  // Request tracker: the architectural fetch PC and the expected in-order output stream
  initial begin
    int   lat;
    int   due;
    fl_t  f;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.redirect_valid) model_pc = bus.redirect_pc & ~32'h3;
        if (bus.imem_req_valid && bus.imem_req_ready) begin
          chk("req_addr", bus.imem_req_addr, model_pc);
          e.pc   = model_pc;
          e.data = mem_word(model_pc);
          exp_q.push_back(e);
          lat = $urandom_range(lat_max, lat_min);
          due = cyc + lat;
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          f.addr = bus.imem_req_addr;
          f.due  = due;
          inflight.push_back(f);
          if (first_fire < 0) first_fire = cyc;
          n_fire++;
          model_pc = model_pc + 32'd4;
        end
      end
    end
  end

  // Output monitor: pops the scoreboard on each downstream handshake
  initial begin
    exp_t e;
    chk_flush = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (chk_flush) chk("flush_clears_valid", 32'(bus.instr_valid), 32'd0);
        chk_flush = bus.redirect_valid;
        if (bus.instr_valid && first_valid < 0) first_valid = cyc;
        if (bus.instr_valid && bus.instr_ready) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_out: actual pc=%h required=none", bus.instr_pc);
          end else begin
            e = exp_q.pop_front();
            chk("out_pc", bus.instr_pc, e.pc);
            chk("out_instr", bus.instr, e.data);
          end
        end
        if (bus.redirect_valid) exp_q.delete();
      end else begin
        chk_flush = 1'b0;
      end
    end
  end

  // Asserted between edges; outputs must fall to reset values without a clock
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    bus.redirect_valid = 1'b0;
    #1;
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_req_addr", bus.imem_req_addr, RESET_PC);
    chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr", bus.instr, 32'd0);
    chk("rst_instr_pc", bus.instr_pc, 32'd0);
    inflight.delete();
    exp_q.delete();
    model_pc    = RESET_PC;
    last_due    = cyc;
    n_fire      = 0;
    first_fire  = -1;
    first_valid = -1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  task automatic wait_first(input string nm, input logic [31:0] pc);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.instr_valid) break;
    end
    chk({nm, "_valid"}, 32'(bus.instr_valid), 32'd1);
    chk({nm, "_pc"}, bus.instr_pc, pc);
  endtask

  task automatic pulse_redirect(input logic [31:0] pc);
    @(posedge clk);
    #1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    @(posedge clk);
    #1;
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst                = 1'b0;
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    model_pc = RESET_PC;
    cyc = 0; last_due = 0; n_fire = 0; first_fire = -1; first_valid = -1;
    n_chk = 0; n_err = 0;
    lat_min = 1; lat_max = 1; req_pct = 100;

    // Streaming from reset with a 1-cycle imem
    do_reset();
    @(negedge clk);
    chk("boot_no_req", 32'(bus.imem_req_valid), 32'd0);
    @(negedge clk);
    chk("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("first_req_addr", bus.imem_req_addr, RESET_PC);
    repeat (30) @(posedge clk);
    chk("fetch_latency", 32'(first_valid - first_fire), 32'd2);

    // Downstream stall: prefetch fills and requests stop
    bus.instr_ready = 1'b0;
    do_reset();
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("stall_req_count", 32'(n_fire), 32'd4);
    chk("stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("stall_head_valid", 32'(bus.instr_valid), 32'd1);
    chk("stall_head_pc", bus.instr_pc, 32'h0);
    @(posedge clk);
    #1;
    bus.instr_ready = 1'b1;
    repeat (20) @(posedge clk);

    // Redirect with slow imem and requests in flight
    lat_min = 3; lat_max = 3;
    repeat (12) @(posedge clk);
    pulse_redirect(32'h0000_0100);
    wait_first("redir_slow", 32'h0000_0100);

    // Back-to-back redirects: only the second target is visible
    repeat (8) @(posedge clk);
    #1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0040;
    @(posedge clk);
    #1;
    bus.redirect_pc    = 32'h0000_0080;
    @(posedge clk);
    #1;
    bus.redirect_valid = 1'b0;
    wait_first("redir_b2b", 32'h0000_0080);

    // Low bits ignored and the PC wraps through zero
    lat_min = 1; lat_max = 1;
    repeat (6) @(posedge clk);
    pulse_redirect(32'hFFFF_FFFB);
    wait_first("redir_wrap", 32'hFFFF_FFF8);
    repeat (12) @(posedge clk);

    // Random traffic: latency, back-pressure, redirects
    lat_min = 1; lat_max = 3; req_pct = 70;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      #1;
      bus.instr_ready    = ($urandom_range(99) < 70);
      bus.redirect_valid = ($urandom_range(99) < 4);
      bus.redirect_pc    = $urandom;
    end
    @(posedge clk);
    #1;
    bus.redirect_valid = 1'b0;

    // Asynchronous reset in the middle of traffic
    repeat (3) @(posedge clk);
    do_reset();
    req_pct = 100;
    bus.instr_ready = 1'b1;
    repeat (25) @(posedge clk);
    chk("restart_fetching", 32'(n_fire > 0), 32'd1);

    // Drain: everything requested must come out exactly once
    req_pct = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (inflight.size() == 0 && exp_q.size() == 0) break;
    end
    @(negedge clk);
    chk("drain_expected_left", 32'(exp_q.size()), 32'd0);
    chk("drain_instr_valid", 32'(bus.instr_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
